div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 21 ++
 rtl/div_step.sv | 25 ++
 rtl/div_seq.sv | 154 +++++++++++++++
 tb/tb_div_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared encodings and defaults for the sequential shift-subtract divider.
// Used by div_seq and div_step.
package div_seq_pkg;

  localparam int unsigned DivDataWDefault = 32;
  localparam int unsigned DivIterDefault  = DivDataWDefault;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the partial remainder left by one,
// bring in the next dividend bit, and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              quo_bit
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    // The partial remainder is always below the divisor, so a successful
    // subtraction leaves a result that fits in DATA_W bits.
    diff     = shifted[DATA_W-1:0] - divisor;
    quo_bit  = (shifted >= {1'b0, divisor});
    rem_next = quo_bit ? diff : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider producing {remainder, quotient}.
// Signed (DIV) support is compiled in only when DIV_SIGNED_EN is defined.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DivDataWDefault,
  parameter int unsigned ITER   = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  div_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] rem_q;

  logic [DATA_W-1:0] op1_mag;
  logic [DATA_W-1:0] op2_mag;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_fin;
  logic [DATA_W-1:0] quo_fin;
  logic              quo_bit;

  div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem          (rem_q),
    .dividend_bit (dividend_q[DATA_W-1]),
    .divisor      (divisor_q),
    .rem_next     (rem_nxt),
    .quo_bit      (quo_bit)
  );

  // The dividend register doubles as the quotient shift register.
  assign quo_nxt = {dividend_q[DATA_W-2:0], quo_bit};

`ifdef DIV_SIGNED_EN
  logic op1_neg;
  logic op2_neg;
  logic quo_neg_q;
  logic rem_neg_q;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
  assign op2_mag = op2_neg ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
  assign quo_fin = quo_neg_q ? (~quo_nxt + DATA_W'(1)) : quo_nxt;
  assign rem_fin = rem_neg_q ? (~rem_nxt + DATA_W'(1)) : rem_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (state_q == DivFree && start_i == DivStart && !annul_i) begin
      quo_neg_q <= op1_neg ^ op2_neg;
      rem_neg_q <= op1_neg;
    end
  end
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign op1_mag = opdata1_i;
  assign op2_mag = opdata2_i;
  assign quo_fin = quo_nxt;
  assign rem_fin = rem_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      result_o   <= '0;
      ready_o    <= DivResultNotReady;
      busy_o     <= 1'b0;
    end else begin
      unique case (state_q)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            dividend_q <= op1_mag;
            divisor_q  <= op2_mag;
            rem_q      <= '0;
            cnt_q      <= '0;
            busy_o     <= 1'b1;
            state_q    <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end

        DivByZero: begin
          busy_o   <= 1'b0;
          result_o <= '0;
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            ready_o <= DivResultReady;
            state_q <= DivEnd;
          end
        end

        DivOn: begin
          if (annul_i) begin
            busy_o   <= 1'b0;
            result_o <= '0;
            state_q  <= DivFree;
          end else begin
            rem_q      <= rem_nxt;
            dividend_q <= quo_nxt;
            cnt_q      <= cnt_q + CntW'(1);
            // The final step writes the sign-corrected result directly.
            if (cnt_q == CntW'(ITER - 1)) begin
              result_o <= {rem_fin, quo_fin};
              ready_o  <= DivResultReady;
              busy_o   <= 1'b0;
              state_q  <= DivEnd;
            end
          end
        end

        DivEnd: begin
          if (start_i == DivStop) begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
            state_q  <= DivFree;
          end
        end

        default: begin
          state_q <= DivFree;
          busy_o  <= 1'b0;
          ready_o <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed vectors, annul, async reset, result hold
// and back-to-back random divides. Signed expectations follow DIV_SIGNED_EN.
`timescale 1ns/1ps
module tb_div_seq;

  localparam int unsigned W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp_signed;
    logic [2*W-1:0] exp_unsigned;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] sb_q[$];

  div_seq #(
    .DATA_W (W),
    .ITER   (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference divide using the language's own / and % (truncating toward zero).
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) return '0;
    if (s && SignedEn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Called at a negedge; returns at the negedge where ready_o is first seen, start_i still high.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] exp, output int lat, output int busy_cyc,
                         output logic [2*W-1:0] res, output bit got);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    sb_q.push_back(exp);
    lat = 0;
    busy_cyc = 0;
    got = 1'b0;
    res = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy_o === 1'b1) busy_cyc++;
      if (ready_o === 1'b1) begin
        got = 1'b1;
        res = result_o;
      end
    end
  endtask

  task automatic release_start();
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    n_tests++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready %b busy %b result %h, want 0 0 0",
               ready_o, busy_o, result_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: ready %b busy %b without start, want 0 0", ready_o, busy_o);
      end
    end
  endtask

  task automatic test_unsigned();
    int lat, bc;
    bit got;
    logic [2*W-1:0] res, exp;
    run_div(32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E, lat, bc, res, got);
    exp = sb_q.pop_front();
    n_tests++;
    if (!got || res !== exp) begin
      n_fail++;
      $display("FAIL unsigned_100_7: result %h ready_seen %0d, want %h", res, got, exp);
    end
    n_tests++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL unsigned_latency: %0d edges, want 33", lat);
    end
    n_tests++;
    if (bc != 32) begin
      n_fail++;
      $display("FAIL unsigned_busy: busy high %0d cycles, want 32", bc);
    end
    release_start();
    n_tests++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL unsigned_release: ready %b busy %b result %h, want 0 0 0",
               ready_o, busy_o, result_o);
    end
  endtask

  task automatic test_signed();
    vec_t v[5];
    int lat, bc;
    bit got;
    logic [2*W-1:0] res, exp;
    v[0] = '{32'hFFFF_FFF9, 32'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_7FFF_FFFC};
    v[1] = '{32'hFFFF_FFF9, 32'h2, 1'b0, 64'h0000_0001_7FFF_FFFC, 64'h0000_0001_7FFF_FFFC};
    v[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000,
             64'h8000_0000_0000_0000};
    v[3] = '{32'h7, 32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD, 64'h0000_0007_0000_0000};
    v[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_0000_0003,
             64'hFFFF_FFF9_0000_0000};
    for (int i = 0; i < 5; i++) begin
      run_div(v[i].a, v[i].b, v[i].s, SignedEn ? v[i].exp_signed : v[i].exp_unsigned,
              lat, bc, res, got);
      exp = sb_q.pop_front();
      n_tests++;
      if (!got || res !== exp || lat != 33) begin
        n_fail++;
        $display("FAIL signed_vec%0d: result %h latency %0d, want %h latency 33",
                 i, res, lat, exp);
      end
      release_start();
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] dvd[3];
    int lat, bc;
    bit got;
    logic [2*W-1:0] res, exp;
    dvd[0] = 32'd12345;
    dvd[1] = 32'h8000_0000;
    dvd[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      run_div(dvd[i], '0, i[0], '0, lat, bc, res, got);
      exp = sb_q.pop_front();
      n_tests++;
      if (!got || res !== exp || lat != 2 || bc != 1) begin
        n_fail++;
        $display("FAIL div_zero%0d: result %h latency %0d busy %0d, want %h latency 2 busy 1",
                 i, res, lat, bc, exp);
      end
      release_start();
    end
  endtask

  task automatic test_annul();
    int lat, bc;
    bit got, seen;
    logic [2*W-1:0] res, exp;
    opdata1_i    = 32'hDEAD_BEEF;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL annul_busy_before: busy %b, want 1", busy_o);
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL annul_idle: busy %b ready %b result %h, want 0 0 0",
               busy_o, ready_o, result_o);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL annul_no_ready: ready seen %0d after annul, want 0", seen);
    end
    run_div(32'hFFFF_FFFF, 32'h1, 1'b0, 64'h0000_0000_FFFF_FFFF, lat, bc, res, got);
    exp = sb_q.pop_front();
    n_tests++;
    if (!got || res !== exp || lat != 33) begin
      n_fail++;
      $display("FAIL annul_followup: result %h latency %0d, want %h latency 33", res, lat, exp);
    end
    release_start();
  endtask

  task automatic test_async_reset();
    int lat, bc;
    bit got;
    logic [2*W-1:0] res, exp;
    opdata1_i    = 32'd1000000;
    opdata2_i    = 32'd7;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_busy_before: busy %b, want 1", busy_o);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: busy %b ready %b result %h, want 0 0 0",
               busy_o, ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL areset_idle: busy %b ready %b, want 0 0", busy_o, ready_o);
      end
    end
    run_div(32'd1000000, 32'd7, 1'b0, 64'h0000_0001_0002_2E09, lat, bc, res, got);
    exp = sb_q.pop_front();
    n_tests++;
    if (!got || res !== exp || lat != 33) begin
      n_fail++;
      $display("FAIL areset_followup: result %h latency %0d, want %h latency 33", res, lat, exp);
    end
    release_start();
  endtask

  task automatic test_hold_end();
    int lat, bc;
    bit got;
    logic [2*W-1:0] res, exp;
    run_div(32'd1000, 32'd33, 1'b0, 64'h0000_000A_0000_001E, lat, bc, res, got);
    exp = sb_q.pop_front();
    n_tests++;
    if (!got || res !== exp) begin
      n_fail++;
      $display("FAIL hold_result: result %h, want %h", res, exp);
    end
    for (int i = 0; i < 5; i++) begin
      opdata1_i    = $urandom();
      opdata2_i    = $urandom();
      signed_div_i = i[0];
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (result_o !== exp || ready_o !== 1'b1 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: result %h ready %b busy %b, want %h 1 0",
                 i, result_o, ready_o, busy_o, exp);
      end
    end
    release_start();
    n_tests++;
    if (ready_o !== 1'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL hold_release: ready %b result %h, want 0 0", ready_o, result_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, want_lat;
    bit got;
    logic [W-1:0] a, b;
    logic s;
    logic [2*W-1:0] res, exp;
    for (int i = 0; i < 10; i++) begin
      a = $urandom();
      b = (i % 4 == 3) ? '0 : ($urandom() >> $urandom_range(0, 31));
      s = 1'($urandom_range(0, 1));
      want_lat = (b == '0) ? 2 : 33;
      run_div(a, b, s, model(a, b, s), lat, bc, res, got);
      exp = sb_q.pop_front();
      n_tests++;
      if (!got || res !== exp || lat != want_lat) begin
        n_fail++;
        $display("FAIL b2b%0d: %h/%h s=%b result %h latency %0d, want %h latency %0d",
                 i, a, b, s, res, lat, exp, want_lat);
      end
      release_start();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_hold_end();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
